// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller keypad path.
// Holds the keypad geometry, the FSM state enum and the key-class enum.
package microwave_pkg;

  localparam int KEYS    = 10;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCKED
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } key_class_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser and settle counter for the raw keypad lines.
// Emits the settled candidate vector and a one-cycle stable flag.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int W               = 10
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] keypad,
  output logic [W-1:0] cand,
  output logic         stable
);

  localparam int                CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_AT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments so every flop here samples pre-edge values;
  // blocking ones would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Saturation one past STABLE_AT makes this a single pulse per settled vector.
  assign stable = (cnt == STABLE_AT);

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: debounce, chord rejection and one strobed digit per press.
// Comes out of reset in HELD so a key held through clear must be re-pressed.
module keypad_encoder
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [KEYS-1:0]    keypad,
  input  logic               enable,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  output logic               key_down,
  output logic               multi_key
);

  logic [KEYS-1:0]    cand;
  logic               stable;
  logic [3:0]         ones;
  logic [DIGIT_W-1:0] key_idx;
  key_class_t         key_class;
  kp_state_t          state, state_next;
  logic               fire;
  logic               load;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .W              (KEYS)
  ) u_debouncer (
    .clk   (clk),
    .clear (clear),
    .keypad(keypad),
    .cand  (cand),
    .stable(stable)
  );

  always_comb begin
    ones    = '0;
    key_idx = '0;
    for (int i = 0; i < KEYS; i++) begin
      ones = ones + 4'(cand[i]);
      if (cand[i]) key_idx = DIGIT_W'(i);
    end
    if (ones == 4'd0)      key_class = NONE;
    else if (ones == 4'd1) key_class = SINGLE;
    else                   key_class = MULTI;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= HELD;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (stable && key_class == SINGLE) begin
          state_next = HELD;
          load       = 1'b1;
          fire       = enable;
        end else if (stable && key_class == MULTI) begin
          state_next = LOCKED;
        end
      end
      HELD: begin
        if (stable && key_class == NONE)       state_next = IDLE;
        else if (stable && key_class == MULTI) state_next = LOCKED;
      end
      LOCKED: begin
        if (stable && key_class == NONE) state_next = IDLE;
      end
      default: state_next = HELD;
    endcase
  end

  // Status flags are taken from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      key_down    <= 1'b1;
      multi_key   <= 1'b0;
    end else begin
      digit_valid <= fire;
      if (load) digit <= key_idx;
      key_down  <= (state_next == HELD);
      multi_key <= (state_next == LOCKED);
    end
  end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Front-end stage of the microwave controller, placed directly upstream of `microwave` on the keypad path. Synchronises and debounces the raw 10-line one-hot keypad, rejects multi-key chords, and emits exactly one 4-bit decimal digit with a single-cycle strobe per clean press. The timer core consumes `digit`/`digit_valid` instead of sampling raw key levels.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive synchronised cycles a key vector must stay unchanged to count as stable; legal range 1..255.
- `KEYS`, 10, keypad line count; fixed at 10, not overridable.
- `clk`  in  1  system clock, 100 Hz (10 ms period).
- `clear`  in  1  reset, asynchronous, active-high.
- `keypad`  in  10  raw, asynchronous; bit i set means key i is held.
- `enable`  in  1  digit entry allowed; low while cooking.
- `digit`  out  4  decimal value of last accepted key, 0..9.
- `digit_valid`  out  1  one-cycle strobe; `digit` is valid in the same cycle.
- `key_down`  out  1  level; a stable single key is held.
- `multi_key`  out  1  level; a stable chord of 2 or more keys is held.

## Operation
- Synchroniser: two flops per line, reset value 0.
- Debounce: `cand` holds the last synchronised vector, and `cnt` counts cycles that vector has been unchanged.
  - When the vector differs from `cand`: load `cand` and set `cnt` to 0.
  - Otherwise: `cnt` increments and saturates at `DEBOUNCE_CYCLES`.
  - `stable` is defined as `cnt == DEBOUNCE_CYCLES-1`, and it is true for exactly one cycle per settled vector.
- Classification of `cand`: NONE if all bits are 0; SINGLE if exactly one bit is set, with index = key value; MULTI if 2 or more bits are set.
- FSM states: IDLE, HELD, LOCKED.
  - IDLE + stable SINGLE: latch `digit`, pulse `digit_valid` if `enable` is high, go to HELD.
  - IDLE + stable MULTI: go to LOCKED.
  - HELD + stable NONE: go to IDLE.
  - HELD + stable MULTI: go to LOCKED.
  - HELD + stable SINGLE with a different key: stay in HELD, no strobe.
  - LOCKED + stable NONE: go to IDLE.
  - LOCKED + anything else: stay in LOCKED.
- `key_down` = (state == HELD). `multi_key` = (state == LOCKED). Both are registered.
- Disabled press: if `enable` is low when the strobe would fire, the strobe is dropped and the FSM still moves to HELD. No digit fires later when `enable` rises.
- Reset values: `digit` = 0, `digit_valid` = 0, FSM = HELD, so `key_down` = 1 and `multi_key` = 0. A key held through `clear` yields no digit until it is released and pressed again.
- `clear` asserted mid-press: everything returns to reset values immediately and asynchronously, including any strobe in flight.

## Timing
- Press latency: `digit_valid` is high during cycle `DEBOUNCE_CYCLES+3`, counted from the first rising edge that samples the new `keypad` value. Default: 7 cycles = 70 ms.
- Release latency: the return to IDLE is visible `DEBOUNCE_CYCLES+3` cycles after release.
- Glitch rejection: a pulse or bounce lasting fewer than `DEBOUNCE_CYCLES` synchronised cycles produces no state change.
- Strobe rate: at most one `digit_valid` per press/release cycle. The minimum key-to-key interval is `2*(DEBOUNCE_CYCLES+3)` cycles.
- Chords: two keys pressed within the debounce window are treated as MULTI, never as the first key alone.
- `digit` holds its value between strobes.

## Structure
- Shared package `microwave_pkg`:
  - `KEYS` = 10, `DIGIT_W` = 4.
  - FSM state enum `kp_state_t` {IDLE, HELD, LOCKED}.
  - Key-class enum {NONE, SINGLE, MULTI}.
- Sub-module `key_debouncer`: synchroniser plus `cand`/`cnt` logic, parameterised by `DEBOUNCE_CYCLES`. Outputs `cand` and `stable`.
- Top-level `keypad_encoder` contains: the classifier (popcount and one-hot-to-index), the FSM, and the output registers.

## Test plan
- Reset with `keypad` = 0, then hold bit 2 for 110 cycles and release -> exactly one `digit_valid` with `digit` = 2, 7 cycles after the press; `key_down` high until 7 cycles after release.
- Sequence 2, 5, 9, 9, 9 (110 cycles held, 110 cycles released each) -> five strobes with digits 2, 5, 9, 9, 9 and no extras.
- Bit 5 toggling every cycle for 3 cycles, then held steady -> no strobe during the bounce; one strobe with `digit` = 5 once the key has been stable for 4 cycles.
- Bits 2 and 7 held together -> `multi_key` = 1 and no strobe. Release bit 7 only -> still no strobe. Release all -> `multi_key` = 0.
- `enable` = 0 while pressing 3, then `enable` raised while 3 is still held -> no strobe at any point. Next press of 3 with `enable` = 1 -> strobe with `digit` = 3.
- `clear` pulsed while 4 is held -> outputs return to reset values asynchronously and no strobe follows. Release and re-press 4 -> one strobe with `digit` = 4.
